// File: rtl/violation_ascii_pkg.sv
// Shared definitions for the violation ASCII streamer: the character
// constants it emits, the message FSM states and the nibble-to-hex helper.
package violation_ascii_pkg;

    localparam logic [7:0] CHAR_R  = 8'h52;
    localparam logic [7:0] CHAR_P  = 8'h50;
    localparam logic [7:0] CHAR_B  = 8'h42;
    localparam logic [7:0] CHAR_X  = 8'h58;
    localparam logic [7:0] CHAR_NL = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        CHAR,
        HEX_HI,
        HEX_LO,
        NL
    } state_e;

    // Uppercase hex digit for one nibble: 0..9 -> '0'..'9', A..F -> 'A'..'F'.
    function automatic logic [7:0] nibbleToHex(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            return 8'h30 + wide;
        end
        return 8'h37 + wide;
    endfunction

endpackage

// File: rtl/viol_code_fifo.sv
// Small synchronous FIFO holding pending violation codes. Pointers carry one
// extra wrap bit so full and empty can be told apart without a counter.
module viol_code_fifo #(
    parameter int CODE_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [CODE_W-1:0] data_i,
    input  logic              pop_i,
    output logic [CODE_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wrPtr_q;
    logic [AW:0]       rdPtr_q;
    logic [CODE_W-1:0] mem_q [DEPTH];
    logic              pushEn;
    logic              popEn;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign pushEn  = push_i && !full_o;
    assign popEn   = pop_i && !empty_o;
    assign data_o  = mem_q[rdPtr_q[AW-1:0]];

    // Pointer registers; a simultaneous push and pop both advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/violation_ascii_streamer.sv
// Buffers violation codes and streams each one out as a short ASCII message
// (R/P/B for legacy codes, X plus two hex digits otherwise, optional newline).
module violation_ascii_streamer
    import violation_ascii_pkg::*;
#(
    parameter int CODE_W    = 2,
    parameter int DEPTH     = 4,
    parameter int APPEND_NL = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        ascii_out,
    output logic              busy,
    output logic [CNT_W-1:0]  msg_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q;
    state_e            state_d;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;
    logic [CNT_W-1:0]  msgCnt_q;
    logic [CNT_W-1:0]  msgCnt_d;

    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPush;
    logic              fifoPop;
    logic [CODE_W-1:0] fifoData;
    logic [7:0]        codeByte;
    logic              xfer;
    logic              msgDone;

    assign in_ready  = !fifoFull;
    assign fifoPush  = in_valid && (code_in != '0);
    assign codeByte  = 8'(code_q);
    assign out_valid = (state_q != IDLE);
    assign xfer      = out_valid && out_ready;
    assign busy      = (state_q != IDLE) || !fifoEmpty;
    assign msg_cnt   = msgCnt_q;

    viol_code_fifo #(
        .CODE_W (CODE_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifoPush),
        .data_i  (code_in),
        .pop_i   (fifoPop),
        .data_o  (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // State, latched code and message counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            code_q   <= '0;
            msgCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            msgCnt_q <= msgCnt_d;
        end
    end

    // Message sequencing and byte selection; the byte depends only on
    // registered state so it holds steady while the sink stalls.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        msgCnt_d  = msgCnt_q;
        fifoPop   = 1'b0;
        msgDone   = 1'b0;
        ascii_out = 8'h00;

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    code_d  = fifoData;
                    state_d = CHAR;
                end
            end
            CHAR: begin
                case (codeByte)
                    8'd1:    ascii_out = CHAR_R;
                    8'd2:    ascii_out = CHAR_P;
                    8'd3:    ascii_out = CHAR_B;
                    default: ascii_out = CHAR_X;
                endcase
                if (xfer) begin
                    if (codeByte >= 8'd4) begin
                        state_d = HEX_HI;
                    end else if (APPEND_NL != 0) begin
                        state_d = NL;
                    end else begin
                        msgDone = 1'b1;
                    end
                end
            end
            HEX_HI: begin
                ascii_out = nibbleToHex(codeByte[7:4]);
                if (xfer) begin
                    state_d = HEX_LO;
                end
            end
            HEX_LO: begin
                ascii_out = nibbleToHex(codeByte[3:0]);
                if (xfer) begin
                    if (APPEND_NL != 0) begin
                        state_d = NL;
                    end else begin
                        msgDone = 1'b1;
                    end
                end
            end
            NL: begin
                ascii_out = CHAR_NL;
                if (xfer) begin
                    msgDone = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (msgDone) begin
            if (msgCnt_q != '1) begin
                msgCnt_d = msgCnt_q + CNT_ONE;
            end
            if (!fifoEmpty) begin
                fifoPop = 1'b1;
                code_d  = fifoData;
                state_d = CHAR;
            end else begin
                state_d = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_violation_ascii_streamer.sv
// Scoreboard bench for the violation ASCII streamer. Two instances share the
// clock: a wide one (CODE_W=8, newline on) and a narrow one (CODE_W=2,
// no newline, 2-bit counter) for the saturation check.
module tb_violation_ascii_streamer;

    logic       clk;
    logic       rstA;
    logic       inValidA;
    logic [7:0] codeA;
    logic       outReadyA;
    logic       inReadyA;
    logic       outValidA;
    logic [7:0] asciiA;
    logic       busyA;
    logic [7:0] msgCntA;

    logic       rstB;
    logic       inValidB;
    logic [1:0] codeB;
    logic       outReadyB;
    logic       inReadyB;
    logic       outValidB;
    logic [7:0] asciiB;
    logic       busyB;
    logic [1:0] msgCntB;

    logic [7:0] expA[$];
    logic [7:0] expB[$];
    logic [7:0] eA;
    logic [7:0] eB;
    logic       prevStallA;
    logic [7:0] prevByteA;
    int         xferA;
    int         xferB;
    int         assertCount;
    int         failCount;
    int         baseA;

    violation_ascii_streamer #(
        .CODE_W    (8),
        .DEPTH     (4),
        .APPEND_NL (1),
        .CNT_W     (8)
    ) dutA (
        .clk       (clk),
        .rst_n     (rstA),
        .in_valid  (inValidA),
        .in_ready  (inReadyA),
        .code_in   (codeA),
        .out_valid (outValidA),
        .out_ready (outReadyA),
        .ascii_out (asciiA),
        .busy      (busyA),
        .msg_cnt   (msgCntA)
    );

    violation_ascii_streamer #(
        .CODE_W    (2),
        .DEPTH     (2),
        .APPEND_NL (0),
        .CNT_W     (2)
    ) dutB (
        .clk       (clk),
        .rst_n     (rstB),
        .in_valid  (inValidB),
        .in_ready  (inReadyB),
        .code_in   (codeB),
        .out_valid (outValidB),
        .out_ready (outReadyB),
        .ascii_out (asciiB),
        .busy      (busyB),
        .msg_cnt   (msgCntB)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case some wait is never satisfied.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor for the wide instance: every accepted byte is popped from the
    // scoreboard, and a stalled byte must still be presented unchanged.
    always @(negedge clk) begin
        if (rstA && prevStallA) begin
            checkOutput("holdA", {23'd0, outValidA, asciiA}, {23'd0, 1'b1, prevByteA});
        end
        if (rstA && outValidA && outReadyA) begin
            xferA++;
            if (expA.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpectedA: got byte 0x%0h, expected no byte at %0t", asciiA, $time);
            end else begin
                eA = expA.pop_front();
                checkOutput("byteA", {24'd0, asciiA}, {24'd0, eA});
            end
        end
        prevStallA = rstA && outValidA && !outReadyA;
        prevByteA  = asciiA;
    end

    // Monitor for the narrow instance: same scoreboard pop and compare.
    always @(negedge clk) begin
        if (rstB && outValidB && outReadyB) begin
            xferB++;
            if (expB.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpectedB: got byte 0x%0h, expected no byte at %0t", asciiB, $time);
            end else begin
                eB = expB.pop_front();
                checkOutput("byteB", {24'd0, asciiB}, {24'd0, eB});
            end
        end
    end

    // Offer one code and queue its hand-computed bytes (packed MSB first).
    task automatic applyStimulus(input int which, input logic [7:0] code, input logic [31:0] bytes, input int n);
        logic rdy;
        logic ok;
        for (int i = 0; i < n; i++) begin
            if (which == 0) expA.push_back(bytes[31-8*i -: 8]);
            else            expB.push_back(bytes[31-8*i -: 8]);
        end
        ok = 1'b0;
        if (which == 0) begin
            inValidA = 1'b1;
            codeA    = code;
        end else begin
            inValidB = 1'b1;
            codeB    = code[1:0];
        end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            rdy = (which == 0) ? inReadyA : inReadyB;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        inValidA = 1'b0;
        inValidB = 1'b0;
        checkOutput("acceptTimeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic waitIdle(input int which);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (which == 0 && expA.size() == 0 && !busyA) begin
                done = 1'b1;
                break;
            end
            if (which == 1 && expB.size() == 0 && !busyB) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("drainTimeout", {31'd0, done}, 32'd1);
    endtask

    task automatic doReset(input int which);
        if (which == 0) rstA = 1'b0;
        else            rstB = 1'b0;
        inValidA = 1'b0;
        inValidB = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (which == 0) begin
            expA.delete();
            rstA = 1'b1;
        end else begin
            expB.delete();
            rstB = 1'b1;
        end
    endtask

    // Directed sequence.
    initial begin
        logic [1:0] codesB [5];
        logic [1:0] cntB   [5];
        logic [7:0] bytesB [5];

        codesB = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        bytesB = '{8'h52, 8'h50, 8'h42, 8'h52, 8'h50};
        cntB   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        assertCount = 0;
        failCount   = 0;
        xferA       = 0;
        xferB       = 0;
        prevStallA  = 1'b0;
        prevByteA   = 8'h00;
        rstA        = 1'b0;
        rstB        = 1'b0;
        inValidA    = 1'b0;
        inValidB    = 1'b0;
        codeA       = 8'h00;
        codeB       = 2'd0;
        outReadyA   = 1'b1;
        outReadyB   = 1'b1;

        doReset(0);
        doReset(1);
        checkOutput("rstOutValid", {31'd0, outValidA}, 32'd0);
        checkOutput("rstAscii",    {24'd0, asciiA},    32'h00);
        checkOutput("rstMsgCnt",   {24'd0, msgCntA},   32'd0);
        checkOutput("rstBusy",     {31'd0, busyA},     32'd0);
        checkOutput("rstInReady",  {31'd0, inReadyA},  32'd1);
        checkOutput("rstMsgCntB",  {30'd0, msgCntB},   32'd0);

        $display("[TB] code 2 with latency check");
        applyStimulus(0, 8'd2, 32'h500A0000, 2);
        checkOutput("latOutValid0", {31'd0, outValidA}, 32'd0);
        checkOutput("latBusy",      {31'd0, busyA},     32'd1);
        @(posedge clk);
        #1;
        checkOutput("latOutValid1", {31'd0, outValidA}, 32'd1);
        checkOutput("latFirstByte", {24'd0, asciiA},    32'h50);
        waitIdle(0);
        checkOutput("cntAfterP",  {24'd0, msgCntA}, 32'd1);
        checkOutput("busyAfterP", {31'd0, busyA},   32'd0);

        $display("[TB] code 0 dropped, then code 3");
        doReset(0);
        applyStimulus(0, 8'd0, 32'h0, 0);
        checkOutput("zeroBusy",     {31'd0, busyA},     32'd0);
        checkOutput("zeroOutValid", {31'd0, outValidA}, 32'd0);
        applyStimulus(0, 8'd3, 32'h420A0000, 2);
        waitIdle(0);
        checkOutput("cntAfterB", {24'd0, msgCntA}, 32'd1);

        $display("[TB] hex codes");
        applyStimulus(0, 8'hA5, 32'h5841350A, 4);
        applyStimulus(0, 8'h04, 32'h5830340A, 4);
        applyStimulus(0, 8'hFF, 32'h5846460A, 4);
        waitIdle(0);
        checkOutput("cntAfterHex", {24'd0, msgCntA}, 32'd4);

        $display("[TB] backpressure and full FIFO");
        doReset(0);
        outReadyA = 1'b0;
        applyStimulus(0, 8'd1, 32'h520A0000, 2);
        applyStimulus(0, 8'd2, 32'h500A0000, 2);
        applyStimulus(0, 8'd3, 32'h420A0000, 2);
        applyStimulus(0, 8'd1, 32'h520A0000, 2);
        applyStimulus(0, 8'd2, 32'h500A0000, 2);
        checkOutput("fullInReady",  {31'd0, inReadyA},  32'd0);
        checkOutput("stallValid",   {31'd0, outValidA}, 32'd1);
        checkOutput("stallByte",    {24'd0, asciiA},    32'h52);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stallByteLate", {24'd0, asciiA},   32'h52);
        checkOutput("stallInReady",  {31'd0, inReadyA}, 32'd0);
        outReadyA = 1'b1;
        baseA = xferA;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("noGapBytes", xferA - baseA, 32'd10);
        waitIdle(0);
        checkOutput("cntAfterBurst", {24'd0, msgCntA}, 32'd5);

        $display("[TB] reset in the middle of a message");
        doReset(0);
        outReadyA = 1'b0;
        applyStimulus(0, 8'h3C, 32'h5833430A, 4);
        applyStimulus(0, 8'd1, 32'h520A0000, 2);
        applyStimulus(0, 8'd2, 32'h500A0000, 2);
        outReadyA = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        outReadyA = 1'b0;
        checkOutput("hexLoByte", {24'd0, asciiA}, 32'h43);
        rstA = 1'b0;
        @(posedge clk);
        #1;
        expA.delete();
        checkOutput("midRstValid",   {31'd0, outValidA}, 32'd0);
        checkOutput("midRstBusy",    {31'd0, busyA},     32'd0);
        checkOutput("midRstMsgCnt",  {24'd0, msgCntA},   32'd0);
        checkOutput("midRstInReady", {31'd0, inReadyA},  32'd1);
        rstA = 1'b1;
        outReadyA = 1'b1;
        baseA = xferA;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("noResidual", xferA - baseA, 32'd0);
        checkOutput("residValid", {31'd0, outValidA}, 32'd0);

        $display("[TB] narrow instance, counter saturation");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, {6'd0, codesB[i]}, {bytesB[i], 24'd0}, 1);
            waitIdle(1);
            checkOutput("satCntB", {30'd0, msgCntB}, {30'd0, cntB[i]});
        end
        checkOutput("bytesB", xferB, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
